wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-side pointer and flag controller for the async FIFO. It sits in the `wclk` domain in front of the dual-port FIFO memory and owns the write address and write enable that drive it. It also produces the Gray-coded write pointer for the read-domain synchronizer and derives full, almost-full, occupancy and overflow status from the synchronized read pointer.

## Interface
- `ADDRSIZE`, 8, memory address bits; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AFULL_LEVEL`, 2**ADDRSIZE-4, occupancy at or above which `walmost_full` asserts.

- `wclk` in 1: write-domain clock; single clock, all state on its rising edge.
- `wrst` in 1: reset, asynchronous, active-high.
- `winc` in 1: write request from the producer.
- `wq2_rptr` in ADDRSIZE+1: Gray read pointer, already two-flop synchronized into `wclk`.
- `wovf_clr` in 1: clears the sticky overflow flag.
- `waddr` out ADDRSIZE: binary write address to memory.
- `wclken` out 1: memory write enable.
- `wptr` out ADDRSIZE+1: Gray write pointer, registered, to the read-domain synchronizer.
- `wfull` out 1: FIFO full, registered.
- `walmost_full` out 1: occupancy >= AFULL_LEVEL, registered.
- `wcount` out ADDRSIZE+1: occupancy seen from the write side, registered, range 0..2**ADDRSIZE.
- `woverflow` out 1: sticky, set by a write attempted while full.

## Operation
- State: binary pointer `wbin` and Gray `wptr`, both ADDRSIZE+1 bits. Also `wfull`, `walmost_full`, `wcount` and `woverflow`.
- `wclken = winc & ~wfull`. This is combinational from the registered `wfull`. Memory writes `waddr` on the same edge.
- `wbnext = wbin + wclken`, modulo 2**(ADDRSIZE+1). `wgnext = (wbnext >> 1) ^ wbnext`.
- `waddr = wbin[ADDRSIZE-1:0]`.
- Full: `wgnext` equals `wq2_rptr` with its two MSBs inverted and the remaining bits equal.
- Occupancy: `rbin = gray2bin(wq2_rptr)`. `wcount_next = wbnext - rbin`, modulo 2**(ADDRSIZE+1).
- `walmost_full_next = (wcount_next >= AFULL_LEVEL)`.
- Overflow:
  - Set when `winc & wfull`.
  - Cleared by `wovf_clr`.
  - Set wins if both occur in the same cycle.
- While full, `winc` is ignored: pointers hold and `wclken` stays 0.
- Wrap-around: `wbin` and `wptr` roll from 2**(ADDRSIZE+1)-1 to 0 with no special handling. `waddr` wraps every 2**ADDRSIZE writes.
- Status is pessimistic. Full and almost-full deassert only after the read pointer advance has crossed the synchronizer. They never deassert early.
- Reset (asynchronous, any time including mid-burst):
  - `wbin`, `wptr`, `waddr`, `wcount` = 0.
  - `wfull`, `walmost_full`, `woverflow` = 0.
  - `wclken` = 0 while `wrst` is high.

## Timing
- Accepted write: `wclken` high in cycle N, memory written at the end of N. `waddr`, `wptr` and `wcount` update at that edge and are visible in N+1.
- `wfull` asserts on the edge that accepts the last free slot. A write in the following cycle is refused.
- `wq2_rptr` change in cycle N: `wfull`, `wcount` and `walmost_full` reflect it in N+1. The 2-cycle synchronizer latency sits outside this block.
- Every output is a register output except `wclken`.
- `wptr` changes at most one bit per edge, which the Gray CDC requires.

## Structure
- Shared package `fifo_pkg`:
  - Default `ADDRSIZE`.
  - Functions `bin2gray` and `gray2bin`, parameterized on width.
  - Constant `PTRSIZE = ADDRSIZE+1`.
- One sub-module, `fifo_gray2bin`: combinational Gray-to-binary conversion for `wq2_rptr`. The read-side controller reuses it.

## Test plan
Bench runs with ADDRSIZE=3 (depth 8) and AFULL_LEVEL=6.
- **Fill.** `wq2_rptr`=0, `winc` high for 8 cycles.
  - `waddr` steps 0..7 and `wclken` is high for 8 cycles.
  - After the 8th edge: `wfull`=1, `wcount`=8, `wptr`=4'b1100.
  - `walmost_full` rises on the edge `wcount` becomes 6.
- **Overflow.** From full, `winc` high for 2 cycles.
  - `wclken`=0, `wptr` and `waddr` unchanged, `woverflow`=1.
  - `wovf_clr` pulse returns it to 0. `wovf_clr` together with `winc` while full leaves it 1.
- **Release.** From full, `wq2_rptr`=4'b0001 (read pointer 1).
  - Next edge: `wfull`=0, `wcount`=7.
  - A single `winc` is then accepted at `waddr`=0 and sets `wfull` again.
- **Wrap.** Continuous writes for 40 cycles, with `wq2_rptr` driven to gray(`wbin`-2) each cycle.
  - `wbin` wraps at 16 and `waddr` at 8.
  - `wfull` never asserts, `wcount` holds at 2 or 3, and `wptr` changes one bit per write.
- **Mid-burst reset.** Assert `wrst` asynchronously between edges at `wcount`=5.
  - All outputs go to 0 before the next edge.
  - Writing resumes at `waddr`=0 after release.
- **Boundary compare.** `wbin`=7 and `wq2_rptr`=gray(15)=4'b1000.
  - Occupancy 8 must not assert `wfull` falsely. The modulo subtraction gives `wcount`=8 only when the pointers differ by exactly 8.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
// Helpers work on 32-bit values, so callers zero-extend narrower pointers and truncate the result.
package fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 8;
  localparam int PTRSIZE = ADDRSIZE_DEFAULT + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unchanged, so any width up to 32 works.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter for synchronized FIFO pointers.
// Shared by the write-side and read-side controllers.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign bin[gi] = ^gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller of the async FIFO (wclk domain).
// Owns the memory write address/enable and the Gray pointer sent to the read domain.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = fifo_pkg::ADDRSIZE_DEFAULT,
  parameter int AFULL_LEVEL = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_reg, wbin_next;
  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] wcount_reg, wcount_next;
  logic          wfull_reg, wfull_next;
  logic          walmost_full_reg, walmost_full_next;
  logic          woverflow_reg, woverflow_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_pattern;

  fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  // Reset is also masked here so no stray memory write can occur while wrst is held.
  assign wclken = winc & ~wfull_reg & ~wrst;

  // Gray pointer one full lap ahead of the read pointer: top two bits inverted.
  assign full_pattern = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};

  always_comb begin
    wbin_next         = wbin_reg + PW'(wclken);
    wptr_next         = PW'(bin2gray(32'(wbin_next)));
    wcount_next       = wbin_next - rbin;
    wfull_next        = (wptr_next == full_pattern);
    walmost_full_next = (wcount_next >= PW'(AFULL_LEVEL));
    woverflow_next    = (winc & wfull_reg) | (woverflow_reg & ~wovf_clr);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_reg         <= '0;
      wptr_reg         <= '0;
      wcount_reg       <= '0;
      wfull_reg        <= 1'b0;
      walmost_full_reg <= 1'b0;
      woverflow_reg    <= 1'b0;
    end else begin
      wbin_reg         <= wbin_next;
      wptr_reg         <= wptr_next;
      wcount_reg       <= wcount_next;
      wfull_reg        <= wfull_next;
      walmost_full_reg <= walmost_full_next;
      woverflow_reg    <= woverflow_next;
    end
  end

  assign waddr        = wbin_reg[ADDRSIZE-1:0];
  assign wptr         = wptr_reg;
  assign wfull        = wfull_reg;
  assign walmost_full = walmost_full_reg;
  assign wcount       = wcount_reg;
  assign woverflow    = woverflow_reg;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl at depth 8 against a pointer-arithmetic reference model.
// Directed fill/overflow/release/wrap/reset/boundary steps, then a randomized producer/consumer phase.
module tb_wptr_full_ctrl;

  localparam int ADDRSIZE    = 3;
  localparam int AFULL_LEVEL = 6;
  localparam int DEPTH       = 8;
  localparam int PMOD        = 16;

  logic                wclk;
  logic                wrst;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wclken;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wcount;
  logic                woverflow;

  wptr_full_ctrl #(.ADDRSIZE(ADDRSIZE), .AFULL_LEVEL(AFULL_LEVEL)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: total writes and read position as plain integers mod 16.
  int m_wr = 0;
  int m_rp = 0;
  int m_count = 0;
  bit m_ovf = 1'b0;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int occ(input int wr, input int rp);
    return (wr - rp + PMOD) % PMOD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs just after an edge, check the combinational side, then the registered side.
  task automatic cycle(input logic inc, input logic clr, input int rp);
    bit acc;
    logic [3:0] prev_ptr;
    winc     = inc;
    wovf_clr = clr;
    m_rp     = rp % PMOD;
    wq2_rptr = gray4(m_rp);
    acc      = inc && (occ(m_wr, m_rp) != DEPTH || m_count != DEPTH);
    acc      = inc && (m_count != DEPTH);
    #1;
    chk("wclken", 32'(wclken), 32'(acc));
    chk("waddr", 32'(waddr), 32'(m_wr % DEPTH));
    prev_ptr = wptr;
    @(posedge wclk);
    #1;
    m_ovf   = (inc && m_count == DEPTH) || (m_ovf && !clr);
    m_wr    = (m_wr + int'(acc)) % PMOD;
    m_count = occ(m_wr, m_rp);
    chk("wptr", 32'(wptr), 32'(gray4(m_wr)));
    chk("wcount", 32'(wcount), 32'(m_count));
    chk("wfull", 32'(wfull), 32'(m_count == DEPTH));
    chk("walmost_full", 32'(walmost_full), 32'(m_count >= AFULL_LEVEL));
    chk("woverflow", 32'(woverflow), 32'(m_ovf));
    chk("wptr_onebit", 32'($countones(prev_ptr ^ wptr) <= 1), 32'd1);
    $display("t=%0t winc=%0b clr=%0b rp=%0d -> waddr=%0d wptr=%b wcount=%0d full=%0b afull=%0b ovf=%0b",
             $time, inc, clr, m_rp, waddr, wptr, wcount, wfull, walmost_full, woverflow);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wclken"}, 32'(wclken), 32'd0);
    chk({tag, "_wptr"}, 32'(wptr), 32'd0);
    chk({tag, "_wcount"}, 32'(wcount), 32'd0);
    chk({tag, "_wfull"}, 32'(wfull), 32'd0);
    chk({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
    chk({tag, "_woverflow"}, 32'(woverflow), 32'd0);
  endtask

  initial begin
    int guard;
    wrst = 1'b1;
    winc = 1'b1;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    #12;
    chk_all_zero("reset");
    @(posedge wclk);
    #1;
    wrst = 1'b0;

    // Fill: 8 writes with the reader parked at 0.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    chk("fill_wfull", 32'(wfull), 32'd1);
    chk("fill_wcount", 32'(wcount), 32'd8);
    chk("fill_wptr", 32'(wptr), 32'b1100);

    // Overflow: refused writes, clear, and set-wins-over-clear.
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    chk("ovf_set", 32'(woverflow), 32'd1);
    chk("ovf_waddr_hold", 32'(waddr), 32'd0);
    cycle(1'b0, 1'b1, 0);
    chk("ovf_clr", 32'(woverflow), 32'd0);
    cycle(1'b1, 1'b1, 0);
    chk("ovf_set_wins", 32'(woverflow), 32'd1);
    cycle(1'b0, 1'b1, 0);

    // Release: reader advances by one, one slot frees, one write refills it.
    cycle(1'b0, 1'b0, 1);
    chk("rel_wfull", 32'(wfull), 32'd0);
    chk("rel_wcount", 32'(wcount), 32'd7);
    cycle(1'b1, 1'b0, 1);
    chk("rel_refull", 32'(wfull), 32'd1);

    // Wrap: reader trails the writer by two for 40 writes.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, m_wr + PMOD - 2);
      chk("wrap_count_range", 32'(wcount == 4'd2 || wcount == 4'd3), 32'd1);
    end

    // Mid-burst reset at occupancy 5, asserted between edges.
    guard = 0;
    while (m_count < 5 && guard < 10) begin
      cycle(1'b1, 1'b0, m_rp);
      guard++;
    end
    chk("pre_reset_count", 32'(wcount), 32'd5);
    #2;
    wrst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge wclk);
    wrst = 1'b0;
    m_wr = 0;
    m_rp = 0;
    m_count = 0;
    m_ovf = 1'b0;
    cycle(1'b1, 1'b0, 0);

    // Boundary: wbin=7 against reader gray(15) is exactly 8 apart.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 15);
    chk("bnd_wcount", 32'(wcount), 32'd8);
    chk("bnd_wfull", 32'(wfull), 32'd1);
    cycle(1'b0, 1'b0, 0);
    chk("bnd_not_full", 32'(wfull), 32'd0);

    // Randomized producer/consumer; reader never overtakes the writer.
    for (int i = 0; i < 300; i++) begin
      int rp;
      rp = m_rp;
      if (m_count > 0 && $urandom_range(0, 2) != 0) rp = m_rp + int'($urandom_range(1, m_count));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
